mac_dot: RTL
============

Name: mac_dot

Overview:
- Parametrised, pipelined multiply-accumulate unit that computes dot products of VEC_LEN element pairs, one pair per accepted beat.
- Generalises the 8-bit MAC tile: configurable operand width, signedness and accumulator width.
- Adds a valid handshake, automatic vector framing, optional saturation with an overflow flag, and registered operand forwarding for systolic chaining.
- Sits as one processing element in the matrix-processor array.

Parameters:
- DATA_W, 8: operand width of a and b.
- ACC_W, 32: accumulator and result width. Must be >= 2*DATA_W.
- SIGNED, 0: 1 = two's-complement operands and accumulator; 0 = unsigned.
- VEC_LEN, 4: products per dot product. Must be >= 1.
- SAT, 1: 1 = clamp the accumulator on overflow; 0 = wrap modulo 2^ACC_W.
- CNT_W, $clog2(VEC_LEN+1): width of the count output (derived).

Ports:
- clk  input  1  clock; all state updates on its rising edge.
- reset  input  1  asynchronous, active-low reset.
- in_valid  input  1  a/b pair valid this cycle.
- a  input  DATA_W  operand A.
- b  input  DATA_W  operand B.
- clear  input  1  synchronous flush of the accumulate pipeline.
- x  output  DATA_W  registered copy of a, for the east neighbour.
- y  output  DATA_W  registered copy of b, for the south neighbour.
- x_valid  output  1  registered in_valid, accompanies x/y.
- acc_out  output  ACC_W  last completed dot product.
- out_valid  output  1  one-cycle pulse: acc_out updated this cycle.
- ovf  output  1  overflow occurred within the vector now on acc_out.
- count  output  CNT_W  products accumulated in the current vector.

Behaviour:
- Reset (reset = 0, asynchronous): every register clears to 0. This includes mult, mult_valid, acc, count, acc_out, out_valid, ovf, x, y and x_valid. Reset asserted mid-vector discards the partial sum.
- Stage 1, edge after in_valid = 1:
  - mult <= a*b, 2*DATA_W wide, signed or unsigned per SIGNED.
  - mult_valid <= 1.
  - When in_valid = 0: mult_valid <= 0 and mult holds.
- Stage 2, on an edge with mult_valid = 1:
  - If count == 0: acc <= ext(mult). The first product of a vector loads; it does not add.
  - Otherwise: acc <= acc + ext(mult).
  - ext() sign-extends when SIGNED = 1, zero-extends otherwise.
  - The add is evaluated at ACC_W+1 bits to detect overflow.
  - SAT = 1: clamp on overflow. Signed limits are 2^(ACC_W-1)-1 and -2^(ACC_W-1); the unsigned limit is 2^ACC_W-1.
  - SAT = 0: wrap.
  - Overflow in either mode sets a sticky per-vector flag. A loading product clears it first.
- Vector completion:
  - When the product being accumulated is element VEC_LEN (count == VEC_LEN-1), on the same edge: acc_out <= new sum, ovf <= new flag, out_valid <= 1, count <= 0.
  - Otherwise count increments and out_valid <= 0.
  - acc_out and ovf hold between results.
  - VEC_LEN = 1: every product completes a vector.
- Latency: the last in_valid sampled at edge k produces out_valid high in the cycle after edge k+1, i.e. 2 cycles.
- Throughput: one pair per cycle, with no stalls. Back-to-back vectors need no gap. Bubbles (in_valid = 0) anywhere in a vector are tolerated; count advances only on valid products.
- clear = 1 at an edge:
  - mult_valid, count, acc and the sticky flag go to 0, and out_valid <= 0.
  - acc_out and ovf hold.
  - An in_valid pair in the same cycle is dropped from accumulation.
  - A product in stage 2 at that edge is discarded, even if it would have completed a vector.
- Forwarding: x, y and x_valid register a, b and in_valid every cycle, independent of clear. x/y update only when in_valid = 1; x_valid always follows in_valid.

Test Plan:
- Unsigned, VEC_LEN = 4: pairs (1,5) (2,6) (3,7) (4,8) on consecutive cycles -> out_valid pulses once, 2 cycles after the last pair, with acc_out = 70, ovf = 0; count sequence 0,1,2,3,0.
- Back-to-back vectors plus bubbles: second vector all (2,3), with one in_valid = 0 cycle mid-vector -> acc_out = 24; first result 70 holds until the second out_valid.
- SIGNED = 1, DATA_W = 8: (-3,7) (-128,-128) (5,-2) (0,9) -> acc_out = 16353; then (-128,127) x4 -> acc_out = -65024 (0xFFFF0200 at 32 bits).
- SAT = 1, ACC_W = 16, unsigned: (255,255) (255,255) (0,0) (0,0) -> acc_out = 65535, ovf = 1; same stimulus with SAT = 0 -> acc_out = 64514, ovf = 1; next clean vector -> ovf = 0.
- clear asserted with the third pair of a vector -> no out_valid for that vector; 4 fresh pairs (1,1) -> acc_out = 4; x/y still show the third pair the cycle after.
- Reset driven low mid-vector (count = 2) -> all outputs 0 immediately, with no clock edge; after release, a fresh vector computes correctly.

Source files
------------

// File: rtl/mac_dot.sv
// mac_dot: pipelined multiply-accumulate processing element.
// It computes dot products of VEC_LEN operand pairs, one pair per accepted beat.
// Stage 1 registers the product a*b. Stage 2 accumulates products, with optional
// saturation, and frames them into vectors. The operands are also forwarded one
// cycle later so that neighbouring elements in a systolic array can reuse them.
module mac_dot #(
  parameter int DATA_W  = 8,
  parameter int ACC_W   = 32,
  parameter int SIGNED  = 0,
  parameter int VEC_LEN = 4,
  parameter int SAT     = 1,
  parameter int CNT_W   = $clog2(VEC_LEN + 1)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  input  logic              clear,
  output logic [DATA_W-1:0] x,
  output logic [DATA_W-1:0] y,
  output logic              x_valid,
  output logic [ACC_W-1:0]  acc_out,
  output logic              out_valid,
  output logic              ovf,
  output logic [CNT_W-1:0]  count
);

  localparam int PROD_W = 2 * DATA_W;
  // Number of bits needed to widen a product to the ACC_W+1 bit adder.
  localparam int EXT_W  = ACC_W + 1 - PROD_W;
  localparam bit IS_SIGNED = (SIGNED != 0);
  localparam bit IS_SAT    = (SAT != 0);
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(VEC_LEN - 1);
  localparam logic [ACC_W-1:0] SIGNED_MAX   = {1'b0, {(ACC_W-1){1'b1}}};
  localparam logic [ACC_W-1:0] SIGNED_MIN   = {1'b1, {(ACC_W-1){1'b0}}};
  localparam logic [ACC_W-1:0] UNSIGNED_MAX = {ACC_W{1'b1}};

  logic [PROD_W-1:0] a_ext;
  logic [PROD_W-1:0] b_ext;
  logic [PROD_W-1:0] product;
  logic [PROD_W-1:0] mult;
  logic              mult_valid;

  logic [ACC_W-1:0]  acc;
  logic              sticky;
  logic              first;
  logic              last;
  logic [ACC_W:0]    base;
  logic [ACC_W:0]    addend;
  logic [ACC_W:0]    sum;
  logic              overflow;
  logic [ACC_W-1:0]  clamp_val;
  logic [ACC_W-1:0]  new_acc;
  logic              new_flag;

  // Widen the operands to the product width. The low PROD_W bits of the plain
  // product are then correct for both two's-complement and unsigned operands.
  always_comb begin
    a_ext   = {{DATA_W{IS_SIGNED & a[DATA_W-1]}}, a};
    b_ext   = {{DATA_W{IS_SIGNED & b[DATA_W-1]}}, b};
    product = a_ext * b_ext;
  end

  // Stage 1: register the product. A pair that arrives together with clear is dropped.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      mult       <= '0;
      mult_valid <= 1'b0;
    end else begin
      if (in_valid) begin
        mult <= product;
      end
      mult_valid <= in_valid & ~clear;
    end
  end

  // Compute the next running sum one bit wider than the accumulator.
  // From that sum, derive overflow, the clamped value and the sticky flag.
  always_comb begin
    first  = (count == '0);
    last   = (count == LAST_IDX);
    base   = first ? '0 : {IS_SIGNED & acc[ACC_W-1], acc};
    addend = {{EXT_W{IS_SIGNED & mult[PROD_W-1]}}, mult};
    sum    = base + addend;
    if (IS_SIGNED) begin
      overflow  = sum[ACC_W] ^ sum[ACC_W-1];
      clamp_val = sum[ACC_W] ? SIGNED_MIN : SIGNED_MAX;
    end else begin
      overflow  = sum[ACC_W];
      clamp_val = UNSIGNED_MAX;
    end
    new_acc  = (overflow && IS_SAT) ? clamp_val : sum[ACC_W-1:0];
    new_flag = (first ? 1'b0 : sticky) | overflow;
  end

  // Stage 2: accumulate the valid products, frame them into vectors and publish each result.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      acc       <= '0;
      sticky    <= 1'b0;
      count     <= '0;
      acc_out   <= '0;
      ovf       <= 1'b0;
      out_valid <= 1'b0;
    end else if (clear) begin
      acc       <= '0;
      sticky    <= 1'b0;
      count     <= '0;
      out_valid <= 1'b0;
    end else if (mult_valid) begin
      acc    <= new_acc;
      sticky <= new_flag;
      if (last) begin
        acc_out   <= new_acc;
        ovf       <= new_flag;
        out_valid <= 1'b1;
        count     <= '0;
      end else begin
        count     <= count + 1'b1;
        out_valid <= 1'b0;
      end
    end else begin
      out_valid <= 1'b0;
    end
  end

  // Forward the operands to the east and south neighbours. Forwarding ignores clear.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      x       <= '0;
      y       <= '0;
      x_valid <= 1'b0;
    end else begin
      if (in_valid) begin
        x <= a;
        y <= b;
      end
      x_valid <= in_valid;
    end
  end

endmodule
